// File: rtl/mcu_debug_bridge.sv
// Debug command executor between mcu_controller and the RISC-V core: halt/resume/reset, RF and data-bus access.
// Optional memory-ack watchdog enabled by defining DBG_MEM_TIMEOUT_EN.
module mcu_debug_bridge #(
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        pause,
    input  logic        resume,
    input  logic        reset,
    input  logic        reg_rd,
    input  logic        reg_wr,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        mem_rw_byte,
    input  logic [31:0] addr,
    input  logic [31:0] d_in,
    output logic        mcu_busy,
    output logic        error,
    output logic [31:0] pc,
    output logic [31:0] d_rd,
    output logic        core_halt,
    input  logic        core_halted,
    output logic        core_rst,
    input  logic [31:0] core_pc,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wdata,
    output logic        rf_we,
    input  logic [31:0] rf_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_re,
    output logic        mem_we,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] HALT_WAIT = 3'd1;
    localparam logic [2:0] RST_PULSE = 3'd2;
    localparam logic [2:0] REG_ACC   = 3'd3;
    localparam logic [2:0] MEM_WAIT  = 3'd4;

    // One counter serves both the reset pulse and the watchdog, sized for the larger.
    localparam int CNT_MAX = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
`ifdef DBG_MEM_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

    logic [2:0]    state_q, state_d;
    logic          paused_q, paused_d;
    logic          busy_q, busy_d;
    logic          error_q, error_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   d_rd_q, d_rd_d;
    logic          core_halt_q, core_halt_d;
    logic          core_rst_q, core_rst_d;
    logic [4:0]    rf_addr_q, rf_addr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;
    logic          rf_we_q, rf_we_d;
    logic          reg_rd_op_q, reg_rd_op_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic          mem_re_q, mem_re_d;
    logic          mem_we_q, mem_we_d;
    logic [1:0]    lane_q, lane_d;
    logic          byte_q, byte_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0] rdata_shifted;
    logic [31:0] rd_result;

    assign rdata_shifted = mem_rdata >> {lane_q, 3'b000};
    assign rd_result     = byte_q ? {24'h0, rdata_shifted[7:0]} : mem_rdata;

    always_comb begin
        // NOTE: every next-state signal gets a default here so no path leaves it unassigned and infers a latch.
        state_d     = state_q;
        paused_d    = paused_q;
        error_d     = 1'b0;
        pc_d        = pc_q;
        d_rd_d      = d_rd_q;
        core_halt_d = core_halt_q;
        core_rst_d  = core_rst_q;
        rf_addr_d   = rf_addr_q;
        rf_wdata_d  = rf_wdata_q;
        rf_we_d     = 1'b0;
        reg_rd_op_d = reg_rd_op_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        lane_d      = lane_q;
        byte_d      = byte_q;
        cnt_d       = cnt_q;

        if (valid && state_q != IDLE) begin
            error_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (valid) begin
                    if (pause) begin
                        core_halt_d = 1'b1;
                        state_d     = HALT_WAIT;
                    end else if (resume) begin
                        // A no-op pass through REG_ACC gives resume its one busy cycle.
                        core_halt_d = 1'b0;
                        paused_d    = 1'b0;
                        reg_rd_op_d = 1'b0;
                        state_d     = REG_ACC;
                    end else if (reset) begin
                        core_rst_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = RST_PULSE;
                    end else if (reg_rd || reg_wr || mem_rd || mem_wr) begin
                        if (!paused_q) begin
                            error_d = 1'b1;
                        end else if (reg_rd) begin
                            rf_addr_d   = addr[4:0];
                            reg_rd_op_d = 1'b1;
                            state_d     = REG_ACC;
                        end else if (reg_wr) begin
                            rf_addr_d   = addr[4:0];
                            rf_wdata_d  = d_in;
                            rf_we_d     = (addr[4:0] != 5'd0);
                            reg_rd_op_d = 1'b0;
                            state_d     = REG_ACC;
                        end else if (!mem_rw_byte && addr[1:0] != 2'b00) begin
                            error_d = 1'b1;
                        end else begin
                            mem_addr_d  = {addr[31:2], 2'b00};
                            mem_be_d    = mem_rw_byte ? (4'b0001 << addr[1:0]) : 4'b1111;
                            mem_wdata_d = mem_rw_byte ? {4{d_in[7:0]}} : d_in;
                            mem_re_d    = mem_rd;
                            mem_we_d    = !mem_rd;
                            lane_d      = addr[1:0];
                            byte_d      = mem_rw_byte;
                            cnt_d       = '0;
                            state_d     = MEM_WAIT;
                        end
                    end
                end
            end
            HALT_WAIT: begin
                if (core_halted) begin
                    pc_d     = core_pc;
                    paused_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            RST_PULSE: begin
                if (cnt_q == RST_LAST) begin
                    core_rst_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REG_ACC: begin
                if (reg_rd_op_q) begin
                    d_rd_d = rf_rdata;
                end
                state_d = IDLE;
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    mem_re_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (mem_re_q) begin
                        d_rd_d = rd_result;
                    end
                    state_d = IDLE;
`ifdef DBG_MEM_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    mem_re_d = 1'b0;
                    mem_we_d = 1'b0;
                    error_d  = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            paused_q    <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            pc_q        <= '0;
            d_rd_q      <= '0;
            core_halt_q <= 1'b0;
            core_rst_q  <= 1'b0;
            rf_addr_q   <= '0;
            rf_wdata_q  <= '0;
            rf_we_q     <= 1'b0;
            reg_rd_op_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            lane_q      <= '0;
            byte_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            paused_q    <= paused_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            pc_q        <= pc_d;
            d_rd_q      <= d_rd_d;
            core_halt_q <= core_halt_d;
            core_rst_q  <= core_rst_d;
            rf_addr_q   <= rf_addr_d;
            rf_wdata_q  <= rf_wdata_d;
            rf_we_q     <= rf_we_d;
            reg_rd_op_q <= reg_rd_op_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            lane_q      <= lane_d;
            byte_q      <= byte_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mcu_busy  = busy_q;
    assign error     = error_q;
    assign pc        = pc_q;
    assign d_rd      = d_rd_q;
    assign core_halt = core_halt_q;
    assign core_rst  = core_rst_q;
    assign rf_addr   = rf_addr_q;
    assign rf_wdata  = rf_wdata_q;
    assign rf_we     = rf_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mcu_debug_bridge.sv
// Directed bench for mcu_debug_bridge; outputs are sampled 1 time unit after each rising edge.
// Define DBG_MEM_TIMEOUT_EN for both files to exercise the watchdog (TIMEOUT_CYCLES=8 here).
module tb_mcu_debug_bridge;

    localparam logic [6:0] S_PAUSE  = 7'b1000000;
    localparam logic [6:0] S_RESUME = 7'b0100000;
    localparam logic [6:0] S_RESET  = 7'b0010000;
    localparam logic [6:0] S_REG_RD = 7'b0001000;
    localparam logic [6:0] S_REG_WR = 7'b0000100;
    localparam logic [6:0] S_MEM_RD = 7'b0000010;
    localparam logic [6:0] S_MEM_WR = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr, mem_rw_byte;
    logic [31:0] addr, d_in;
    logic        mcu_busy, error, core_halt, core_rst, rf_we, mem_re, mem_we;
    logic [31:0] pc, d_rd, rf_wdata, mem_addr, mem_wdata;
    logic [4:0]  rf_addr;
    logic [3:0]  mem_be;
    logic        core_halted, mem_ack;
    logic [31:0] core_pc, rf_rdata, mem_rdata;

    int checks   = 0;
    int failures = 0;
    int cnt;

    always #5 clk = ~clk;

    mcu_debug_bridge #(.RST_CYCLES(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .valid(valid),
        .pause(pause), .resume(resume), .reset(reset),
        .reg_rd(reg_rd), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rw_byte(mem_rw_byte), .addr(addr), .d_in(d_in),
        .mcu_busy(mcu_busy), .error(error), .pc(pc), .d_rd(d_rd),
        .core_halt(core_halt), .core_halted(core_halted), .core_rst(core_rst), .core_pc(core_pc),
        .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_rdata(rf_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_re(mem_re), .mem_we(mem_we), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one command for a single cycle N; returns at N+1.
    task automatic send(input logic [6:0] s, input logic byte_m, input logic [31:0] a, input logic [31:0] d);
        {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr} = s;
        mem_rw_byte = byte_m;
        addr  = a;
        d_in  = d;
        valid = 1'b1;
        step();
        valid = 1'b0;
        {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr} = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1;
        valid = 1'b0;
        {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr} = '0;
        mem_rw_byte = 1'b0;
        addr = '0; d_in = '0;
        core_halted = 1'b0; core_pc = 32'h0000_0104;
        rf_rdata = 32'hCAFE_F00D;
        mem_ack = 1'b0; mem_rdata = '0;
        step(); step();
        rst = 1'b0;
        step();

        check("rst_busy", mcu_busy, 0);
        check("rst_error", error, 0);
        check("rst_pc", pc, 0);
        check("rst_d_rd", d_rd, 0);
        check("rst_core_halt", core_halt, 0);
        check("rst_mem_re", mem_re, 0);

        // Access while not paused is rejected.
        send(S_MEM_RD, 1'b0, 32'h0000_0100, 0);
        check("unpaused_rd_error", error, 1);
        check("unpaused_rd_busy", mcu_busy, 0);
        check("unpaused_rd_mem_re", mem_re, 0);
        step();
        check("unpaused_rd_error_drop", error, 0);

        // Pause: core_halted arrives during the fourth HALT_WAIT cycle.
        send(S_PAUSE, 1'b0, 0, 0);
        check("pause_core_halt", core_halt, 1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (mcu_busy) cnt++;
            if (i == 3) core_halted = 1'b1;
            step();
        end
        check("pause_busy_cycles", cnt, 4);
        check("pause_busy_done", mcu_busy, 0);
        check("pause_pc", pc, 32'h0000_0104);
        check("pause_core_halt_held", core_halt, 1);

        send(S_PAUSE, 1'b0, 0, 0);
        check("repause_busy", mcu_busy, 1);
        step();
        check("repause_done", mcu_busy, 0);

        // Register write then read back.
        send(S_REG_WR, 1'b0, 32'd5, 32'hCAFE_F00D);
        check("regwr_we", rf_we, 1);
        check("regwr_addr", rf_addr, 5);
        check("regwr_wdata", rf_wdata, 32'hCAFE_F00D);
        check("regwr_busy", mcu_busy, 1);
        step();
        check("regwr_we_drop", rf_we, 0);
        check("regwr_idle", mcu_busy, 0);

        send(S_REG_RD, 1'b0, 32'd5, 0);
        check("regrd_addr", rf_addr, 5);
        check("regrd_d_rd_early", d_rd, 0);
        step();
        check("regrd_d_rd", d_rd, 32'hCAFE_F00D);
        check("regrd_idle", mcu_busy, 0);

        send(S_REG_WR, 1'b0, 32'd0, 32'h1234_5678);
        check("regwr0_we", rf_we, 0);
        check("regwr0_busy", mcu_busy, 1);
        step();
        check("regwr0_we_after", rf_we, 0);
        check("regwr0_idle", mcu_busy, 0);

        // Byte read from lane 3, ack two cycles after the request.
        send(S_MEM_RD, 1'b1, 32'h0000_1003, 0);
        check("brd_mem_re", mem_re, 1);
        check("brd_mem_we", mem_we, 0);
        check("brd_addr", mem_addr, 32'h0000_1000);
        check("brd_be", mem_be, 4'b1000);
        step();
        check("brd_re_held", mem_re, 1);
        step();
        mem_ack = 1'b1;
        mem_rdata = 32'hAABB_CCDD;
        step();
        mem_ack = 1'b0;
        check("brd_re_drop", mem_re, 0);
        check("brd_idle", mcu_busy, 0);
        check("brd_d_rd", d_rd, 32'h0000_00AA);

        // Byte write acked in the first request cycle.
        send(S_MEM_WR, 1'b1, 32'h0000_2001, 32'h1234_5678);
        mem_ack = 1'b1;
        check("bwr_mem_we", mem_we, 1);
        check("bwr_be", mem_be, 4'b0010);
        check("bwr_wdata", mem_wdata, 32'h7878_7878);
        check("bwr_addr", mem_addr, 32'h0000_2000);
        step();
        mem_ack = 1'b0;
        check("bwr_we_drop", mem_we, 0);
        check("bwr_idle", mcu_busy, 0);
        check("bwr_d_rd_kept", d_rd, 32'h0000_00AA);

        // Misaligned word write.
        send(S_MEM_WR, 1'b0, 32'h0000_2002, 32'hDEAD_BEEF);
        check("mis_error", error, 1);
        check("mis_mem_we", mem_we, 0);
        check("mis_busy", mcu_busy, 0);
        step();
        check("mis_error_drop", error, 0);

        // Core reset pulse; halt state is untouched.
        send(S_RESET, 1'b0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (core_rst) cnt++;
            step();
        end
        check("rstcmd_pulse_cycles", cnt, 4);
        check("rstcmd_idle", mcu_busy, 0);
        check("rstcmd_core_halt", core_halt, 1);

        // Priority: pause wins over resume, so still halted afterwards.
        send(S_PAUSE | S_RESUME, 1'b0, 0, 0);
        step();
        check("prio_core_halt", core_halt, 1);

        send(S_RESUME, 1'b0, 0, 0);
        check("resume_core_halt", core_halt, 0);
        check("resume_busy", mcu_busy, 1);
        step();
        check("resume_idle", mcu_busy, 0);
        send(S_REG_RD, 1'b0, 32'd5, 0);
        check("resumed_regrd_error", error, 1);
        step();

        send(S_PAUSE, 1'b0, 0, 0);
        step();
        check("repause2_idle", mcu_busy, 0);

        // Word read that never gets acked; a second command while busy is rejected.
        send(S_MEM_RD, 1'b0, 32'h0000_3000, 0);
        check("wrd_be", mem_be, 4'b1111);
        check("wrd_mem_re", mem_re, 1);
        send(S_REG_RD, 1'b0, 32'd1, 0);
        check("busy_cmd_error", error, 1);
        check("busy_cmd_busy", mcu_busy, 1);
`ifdef DBG_MEM_TIMEOUT_EN
        for (int i = 0; i < 6; i++) step();
        check("to_pre_error", error, 0);
        check("to_pre_busy", mcu_busy, 1);
        step();
        check("to_error", error, 1);
        check("to_idle", mcu_busy, 0);
        check("to_mem_re", mem_re, 0);
        check("to_d_rd_kept", d_rd, 32'h0000_00AA);
        step();
        check("to_error_drop", error, 0);
        send(S_MEM_RD, 1'b0, 32'h0000_3004, 0);
        step();
`else
        for (int i = 0; i < 20; i++) step();
        check("wait_busy", mcu_busy, 1);
        check("wait_mem_re", mem_re, 1);
`endif
        // Asynchronous reset in the middle of MEM_WAIT.
        #3;
        rst = 1'b1;
        #1;
        check("arst_mem_re", mem_re, 0);
        check("arst_busy", mcu_busy, 0);
        check("arst_core_halt", core_halt, 0);
        check("arst_pc", pc, 0);
        check("arst_d_rd", d_rd, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_mem_be", mem_be, 0);
        step();
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
